vedic_mac8: RTL and testbench

Streaming multiply-accumulate stage that sits directly downstream of the team's combinational 8x8 Vedic multiplier (Multiplier8x8) and consumes its 16-bit product. It registers operand pairs on a valid/ready handshake, drives them into one Multiplier8x8 instance, and registers the product. It accumulates products over a frame delimited by `in_last`, then presents the frame sum on a held valid/ready output port.

---
 rtl/vedic_mac8.sv | 173 +++++++++++++++++
 tb/tb_vedic_mac8.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mac8.sv
// Streaming multiply-accumulate stage around an 8x8 Vedic multiplier; sums a*b over in_last-delimited frames.
// Optional feature: define VEDIC_MAC_SATURATE_EN to clamp the accumulator instead of wrapping.
module vedic_mac8 #(
  parameter int unsigned N     = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_HOLD} state_t;

  // Urdhva-tiryagbhyam building blocks: 2x2 -> 4x4 -> 8x8 (Multiplier8x8 structure)
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, c, hh;
    t1  = x[1] & y[0];
    t2  = x[0] & y[1];
    c   = t1 & t2;
    hh  = x[1] & y[1];
    vm2 = {hh & c, hh ^ c, t1 ^ t2, x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] ll, lh, hl, hh;
    logic [4:0] mid;
    ll  = vm2(x[1:0], y[1:0]);
    lh  = vm2(x[1:0], y[3:2]);
    hl  = vm2(x[3:2], y[1:0]);
    hh  = vm2(x[3:2], y[3:2]);
    mid = {1'b0, lh} + {1'b0, hl};
    vm4 = {hh, 4'h0} + {1'b0, mid, 2'b00} + {4'h0, ll};
  endfunction

  function automatic logic [15:0] multiplier8x8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ll, lh, hl, hh;
    logic [8:0] mid;
    ll  = vm4(x[3:0], y[3:0]);
    lh  = vm4(x[3:0], y[7:4]);
    hl  = vm4(x[7:4], y[3:0]);
    hh  = vm4(x[7:4], y[7:4]);
    mid = {1'b0, lh} + {1'b0, hl};
    multiplier8x8 = {hh, 8'h00} + {3'b000, mid, 4'h0} + {8'h00, ll};
  endfunction

  state_t state, state_n;

  logic             s1_vld, s1_last;
  logic [N-1:0]     s1_a, s1_b;
  logic             s2_vld, s2_last;
  logic [PW-1:0]    s2_prod;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;

  logic             accept_c;
  logic             load_c;
  logic [PW-1:0]    prod_c;
  logic [ACC_W:0]   wide_c;
  logic             carry_c;
  logic [ACC_W-1:0] nsum_c;

  assign accept_c = in_valid & in_ready;
  assign prod_c   = multiplier8x8(s1_a, s1_b);
  assign wide_c   = {1'b0, acc} + (ACC_W + 1)'(s2_prod);
  assign carry_c  = wide_c[ACC_W];

`ifdef VEDIC_MAC_SATURATE_EN
  // Once clamped, any further non-zero product carries again, so the clamp sticks
  assign nsum_c = carry_c ? {ACC_W{1'b1}} : wide_c[ACC_W-1:0];
`else
  assign nsum_c = wide_c[ACC_W-1:0];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ACC;
    else     state <= state_n;
  end

  // Next-state and result-load strobe
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    case (state)
      ST_ACC:   if (accept_c && in_last) state_n = ST_FLUSH;
      ST_FLUSH: if (s2_vld && s2_last) begin
                  load_c  = 1'b1;
                  state_n = ST_HOLD;
                end
      ST_HOLD:  if (out_valid && out_ready) state_n = ST_ACC;
      default:  state_n = ST_ACC;
    endcase
  end

  // Operand and product pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_prod <= '0;
    end else begin
      s1_vld  <= accept_c;
      s2_vld  <= s1_vld;
      s2_last <= s1_vld & s1_last;
      s2_prod <= prod_c;
      if (accept_c) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_last <= in_last;
      end
    end
  end

  // Frame accumulator, beat counter and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (load_c) begin
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
      end else begin
        if (s2_vld) begin
          acc        <= nsum_c;
          ovf_sticky <= ovf_sticky | carry_c;
        end
        if (accept_c) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Registered handshake and result port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else begin
      in_ready <= (state_n == ST_ACC);
      if (load_c) begin
        out_valid <= 1'b1;
        out_sum   <= nsum_c;
        out_count <= cnt;
        overflow  <= ovf_sticky | carry_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mac8.sv
// Table-driven bench for vedic_mac8 (ACC_W=16) with a result scoreboard; honours VEDIC_MAC_SATURATE_EN.
module tb_vedic_mac8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  a, b;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        overflow;

  int ntests = 0;
  int nfail  = 0;

  vedic_mac8 #(.N(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef VEDIC_MAC_SATURATE_EN
  localparam logic [15:0] OV2 = 16'd65535;
  localparam logic [15:0] OV3 = 16'd65535;
`else
  localparam logic [15:0] OV2 = 16'd64514;
  localparam logic [15:0] OV3 = 16'd64515;
`endif

  typedef struct {
    int              nb;
    logic [3:0][7:0] va;
    logic [3:0][7:0] vb;
    int              gap;
    logic [15:0]     esum;
    logic [7:0]      ecnt;
    logic            eovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  vec_t vecs[12];
  int   nv = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int nb, input logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3,
                         input int gap, input logic [15:0] esum, input logic [7:0] ecnt,
                         input logic eovf);
    vecs[nv].nb    = nb;
    vecs[nv].va[0] = a0; vecs[nv].vb[0] = b0;
    vecs[nv].va[1] = a1; vecs[nv].vb[1] = b1;
    vecs[nv].va[2] = a2; vecs[nv].vb[2] = b2;
    vecs[nv].va[3] = a3; vecs[nv].vb[3] = b3;
    vecs[nv].gap   = gap;
    vecs[nv].esum  = esum;
    vecs[nv].ecnt  = ecnt;
    vecs[nv].eovf  = eovf;
    nv++;
  endtask

  task automatic push_exp(input logic [15:0] s, input logic [7:0] c, input logic o);
    exp_t e;
    e.sum = s; e.cnt = c; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic beat(input logic [7:0] xa, input logic [7:0] xb, input logic xl);
    a = xa; b = xb; in_last = xl; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Scoreboard: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL unexpected_result: got sum %0d count %0d, expected none", out_sum, out_count);
      end else begin
        mon_e = sb.pop_front();
        check("out_sum", int'(out_sum), int'(mon_e.sum));
        check("out_count", int'(out_count), int'(mon_e.cnt));
        check("overflow", int'(overflow), int'(mon_e.ovf));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b1;

    add_vec(1, 255, 255, 0, 0, 0, 0, 0, 0,   0, 16'd65025, 8'd1, 1'b0);
    add_vec(4, 3, 5, 10, 20, 0, 77, 255, 1,  0, 16'd470,   8'd4, 1'b0);
    add_vec(4, 3, 5, 10, 20, 0, 77, 255, 1,  2, 16'd470,   8'd4, 1'b0);
    add_vec(2, 255, 255, 255, 255, 0, 0, 0, 0, 0, OV2,     8'd2, 1'b1);
    add_vec(3, 255, 255, 255, 255, 1, 1, 0, 0, 1, OV3,     8'd3, 1'b1);
    add_vec(3, 0, 0, 0, 255, 255, 0, 0, 0,   0, 16'd0,     8'd3, 1'b0);
    add_vec(2, 128, 2, 1, 1, 0, 0, 0, 0,     0, 16'd257,   8'd2, 1'b0);
    add_vec(4, 17, 15, 200, 100, 99, 99, 12, 34, 1, 16'd30464, 8'd4, 1'b0);
    add_vec(2, 170, 85, 85, 170, 0, 0, 0, 0, 0, 16'd28900, 8'd2, 1'b0);
    add_vec(1, 254, 253, 0, 0, 0, 0, 0, 0,   0, 16'd64262, 8'd1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Table: out_ready held high ahead of out_valid
    for (int i = 0; i < nv; i++) begin
      wait_ready();
      for (int j = 0; j < vecs[i].nb; j++) begin
        if (j == vecs[i].nb - 1) begin
          push_exp(vecs[i].esum, vecs[i].ecnt, vecs[i].eovf);
          beat(vecs[i].va[j], vecs[i].vb[j], 1'b1);
        end else begin
          beat(vecs[i].va[j], vecs[i].vb[j], 1'b0);
          repeat (vecs[i].gap) begin @(posedge clk); #1; end
        end
      end
      check("in_ready_after_last", int'(in_ready), 0);
    end

    // Latency and backpressure
    wait_ready();
    out_ready = 1'b0;
    push_exp(16'd65025, 8'd1, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    check("lat_in_ready_e0", int'(in_ready), 0);
    check("lat_valid_e0", int'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid_e1", int'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid_e2", int'(out_valid), 1);
    check("lat_sum_e2", int'(out_sum), 65025);
    a = 8'd9; b = 8'd9; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid", int'(out_valid), 1);
      check("bp_sum", int'(out_sum), 65025);
      check("bp_count", int'(out_count), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_valid_low", int'(out_valid), 0);
    check("hs_in_ready", int'(in_ready), 1);

    // Reset mid-frame discards the partial sum
    beat(8'd7, 8'd9, 1'b0);
    beat(8'd4, 8'd4, 1'b0);
    rst = 1'b1;
    #1;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_out_sum", int'(out_sum), 0);
    check("mrst_out_count", int'(out_count), 0);
    check("mrst_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready();
    push_exp(16'd6, 8'd1, 1'b0);
    beat(8'd2, 8'd3, 1'b1);

    // Reset mid-HOLD drops the unconsumed result
    wait_ready();
    out_ready = 1'b0;
    beat(8'd5, 8'd5, 1'b1);
    for (int k = 0; k < 10 && !out_valid; k++) begin @(posedge clk); #1; end
    check("hold_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("hrst_out_valid", int'(out_valid), 0);
    check("hrst_out_sum", int'(out_sum), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hrst_in_ready", int'(in_ready), 1);

    // 256-beat frame: beat count wraps to 0
    wait_ready();
    for (int k = 0; k < 256; k++) begin
      if (k == 255) begin
        push_exp(16'd256, 8'd0, 1'b0);
        beat(8'd1, 8'd1, 1'b1);
      end else begin
        beat(8'd1, 8'd1, 1'b0);
      end
    end

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
